keypad_player: RTL and testbench

Transmit-side counterpart of keypad_driver. Accepts eBCD key codes over a valid/ready handshake, buffers them in a small FIFO, and replays each one as an active-low 16-bit pushbutton waveform on pb: press for PRESS_CYC cycles, then release for RELEASE_CYC cycles. It sits in front of keypad_driver's pb input, in place of the physical keypad, for self-test and demo sequences on the calculator.

---
 rtl/calc_pkg.sv | 63 ++++++
 rtl/key_fifo.sv | 55 +++++
 rtl/keypad_player.sv | 168 ++++++++++++++++
 tb/tb_keypad_player.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared calculator definitions: eBCD key codes, keypad player
//               FSM state encoding and the eBCD to pushbutton one-hot map.
// Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

  // eBCD key codes: bit4 marks a valid key, bits3:0 select the key
  localparam logic [4:0] KEY_0   = 5'h10;
  localparam logic [4:0] KEY_1   = 5'h11;
  localparam logic [4:0] KEY_2   = 5'h12;
  localparam logic [4:0] KEY_3   = 5'h13;
  localparam logic [4:0] KEY_4   = 5'h14;
  localparam logic [4:0] KEY_5   = 5'h15;
  localparam logic [4:0] KEY_6   = 5'h16;
  localparam logic [4:0] KEY_7   = 5'h17;
  localparam logic [4:0] KEY_8   = 5'h18;
  localparam logic [4:0] KEY_9   = 5'h19;
  localparam logic [4:0] KEY_MUL = 5'h1A;
  localparam logic [4:0] KEY_DIV = 5'h1B;
  localparam logic [4:0] KEY_PM  = 5'h1C;
  localparam logic [4:0] KEY_ANS = 5'h1D;
  localparam logic [4:0] KEY_RST = 5'h1E;
  localparam logic [4:0] KEY_EQ  = 5'h1F;

  // Keypad player sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Pushbutton bit position of each key on the physical keypad matrix.
  // Codes without the valid flag map to no button at all.
  function automatic logic [15:0] ebcd_to_onehot(input logic [4:0] code);
    logic [15:0] oh;
    oh = '0;
    case (code)
      KEY_1:   oh[0]  = 1'b1;
      KEY_2:   oh[1]  = 1'b1;
      KEY_3:   oh[2]  = 1'b1;
      KEY_DIV: oh[3]  = 1'b1;
      KEY_4:   oh[4]  = 1'b1;
      KEY_5:   oh[5]  = 1'b1;
      KEY_6:   oh[6]  = 1'b1;
      KEY_MUL: oh[7]  = 1'b1;
      KEY_7:   oh[8]  = 1'b1;
      KEY_8:   oh[9]  = 1'b1;
      KEY_9:   oh[10] = 1'b1;
      KEY_PM:  oh[11] = 1'b1;
      KEY_RST: oh[12] = 1'b1;
      KEY_0:   oh[13] = 1'b1;
      KEY_ANS: oh[14] = 1'b1;
      KEY_EQ:  oh[15] = 1'b1;
      default: oh     = '0;
    endcase
    return oh;
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo
// Description : Synchronous FIFO of 5-bit eBCD codes. Pointers carry one
//               extra wrap bit so full and empty are told apart without a
//               separate counter. Push when full and pop when empty are
//               ignored.
// Revision    : 1.0  initial release
// ============================================================================
module key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       sw_clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [4:0] i_din,
  input  logic       i_pop,
  output logic [4:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [4:0]    r_mem [DEPTH];
  logic [c_AW:0] r_wr;
  logic [c_AW:0] r_rd;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[c_AW] != r_rd[c_AW]) &&
                     (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd[c_AW-1:0]];

  // Pointer update; both may move in the same cycle
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty gates every read
  always_ff @(posedge sw_clk) begin
    if (w_do_push) r_mem[r_wr[c_AW-1:0]] <= i_din;
  end

endmodule : key_fifo
`default_nettype wire

// File: rtl/keypad_player.sv
`default_nettype none
// ============================================================================
// Module      : keypad_player
// Description : Queues eBCD key codes from a valid/ready source and replays
//               each as an active-low one-hot pushbutton pulse on pb: held
//               for PRESS_CYC cycles, then released for RELEASE_CYC cycles.
//               Codes without the valid flag are swallowed and flagged on
//               drop.
//               Optional: KEYPAD_PLAYER_CHECK_EN adds eBCD_in/mismatch to
//               compare the decoded key from keypad_driver against the key
//               being played.
// Revision    : 1.0  initial release
// ============================================================================
module keypad_player
  import calc_pkg::*;
#(
  parameter int PRESS_CYC   = 4,
  parameter int RELEASE_CYC = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        sw_clk,
  input  logic        rst,
`ifdef KEYPAD_PLAYER_CHECK_EN
  input  logic [4:0]  eBCD_in,
  output logic        mismatch,
`endif
  input  logic [4:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [15:0] pb,
  output logic        busy,
  output logic        drop
);

  localparam logic [7:0] c_PRESS_LD   = 8'(PRESS_CYC - 1);
  localparam logic [7:0] c_RELEASE_LD = 8'(RELEASE_CYC - 1);

  logic        w_full;
  logic        w_empty;
  logic [4:0]  w_head;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_timer;
  logic [7:0]  w_timer_nxt;
  logic [15:0] r_pb;
  logic [15:0] w_pb_nxt;
  logic        r_drop;

  // A handshake completes whenever the FIFO has room; only valid keys are stored
  assign w_accept = key_valid && !w_full;
  assign w_push   = w_accept && key_code[4];

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sw_clk  (sw_clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (key_code),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer: pop a key, hold its button, then hold all buttons released
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pb_nxt    = r_pb;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_pb_nxt    = ~ebcd_to_onehot(w_head);
          w_timer_nxt = c_PRESS_LD;
          w_state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (r_timer == 8'd0) begin
          w_pb_nxt    = '1;
          w_timer_nxt = c_RELEASE_LD;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      ST_RELEASE: begin
        if (r_timer == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: begin
        w_pb_nxt    = '1;
        w_timer_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset releases every button at once
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pb    <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pb    <= w_pb_nxt;
    end
  end

  // Discard pulse for accepted codes lacking the valid-key flag
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_accept && !key_code[4];
    end
  end

  assign key_ready = !w_full;
  assign pb        = r_pb;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign drop      = r_drop;

`ifdef KEYPAD_PLAYER_CHECK_EN
  logic [4:0] r_cur;
  logic       r_seen;
  logic       r_mismatch;
  logic       w_hit;
  logic       w_end;

  // First decoded key inside the press/release window is the one judged
  assign w_hit = (r_state != ST_IDLE) && !r_seen && eBCD_in[4];
  assign w_end = (r_state == ST_RELEASE) && (r_timer == 8'd0);

  // Loop-back checker: wrong or missing decode latches mismatch until reset
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      r_cur      <= '0;
      r_seen     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur  <= w_head;
        r_seen <= 1'b0;
      end else if (w_hit) begin
        r_seen <= 1'b1;
      end
      if (w_hit && (eBCD_in != r_cur)) r_mismatch <= 1'b1;
      if (w_end && !r_seen && !w_hit)  r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule : keypad_player
`default_nettype wire

// File: tb/tb_keypad_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_player
// Description : Self-checking bench for keypad_player. A timeline model
//               derives, for every accepted key, the sample at which its
//               button goes low, and from that the expected pb, busy,
//               key_ready and drop on every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_player;

  localparam int P     = 4;
  localparam int R     = 4;
  localparam int DEPTH = 8;

  logic        sw_clk;
  logic        rst;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] pb;
  logic        busy;
  logic        drop;
`ifdef KEYPAD_PLAYER_CHECK_EN
  logic [4:0]  eBCD_in;
  logic        mismatch;
`endif

  int n_pass   = 0;
  int n_checks = 0;

  // Timeline model: accept sample, first-low sample and code per played key
  int         t;
  int         a_q[$];
  int         s_q[$];
  logic [4:0] c_q[$];
  int         last_s;
  bit         exp_drop;
  bit         last_acc;
  int         bit_of[16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 7, 3, 11, 14, 12, 15};

  keypad_player #(
    .PRESS_CYC   (P),
    .RELEASE_CYC (R),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sw_clk    (sw_clk),
    .rst       (rst),
`ifdef KEYPAD_PLAYER_CHECK_EN
    .eBCD_in   (eBCD_in),
    .mismatch  (mismatch),
`endif
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .pb        (pb),
    .busy      (busy),
    .drop      (drop)
  );

  initial begin
    sw_clk = 1'b0;
    forever #5 sw_clk = ~sw_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic int in_fifo(int tt);
    int n = 0;
    foreach (a_q[i]) if (a_q[i] <= tt && tt < s_q[i]) n++;
    return n;
  endfunction

  function automatic logic exp_ready(int tt);
    return in_fifo(tt) < DEPTH;
  endfunction

  function automatic logic [15:0] exp_pb(int tt);
    logic [15:0] v = 16'hFFFF;
    logic [4:0]  c;
    foreach (s_q[i]) begin
      if (tt >= s_q[i] && tt < s_q[i] + P) begin
        c = c_q[i];
        v[bit_of[c[3:0]]] = 1'b0;
      end
    end
    return v;
  endfunction

  function automatic logic exp_busy(int tt);
    foreach (a_q[i]) if (a_q[i] <= tt && tt <= s_q[i] + P + R - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int low_bit(logic [15:0] v);
    for (int i = 0; i < 16; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    t = 0;
    a_q.delete();
    s_q.delete();
    c_q.delete();
    last_s   = -1000;
    exp_drop = 1'b0;
    last_acc = 1'b0;
  endtask

  // Advance one clock, sample #1 after the edge, and update the model
  task automatic tick();
    logic       acc;
    logic [4:0] code;
    int         s;
    acc  = key_valid && rst && exp_ready(t);
    code = key_code;
    @(posedge sw_clk);
    #1;
    t++;
    last_acc = acc;
    exp_drop = acc && !code[4];
    if (acc && code[4]) begin
      s = t + 1;
      if (last_s + P + R + 1 > s) s = last_s + P + R + 1;
      a_q.push_back(t);
      s_q.push_back(s);
      c_q.push_back(code);
      last_s = s;
    end
  endtask

  task automatic apply_reset();
    key_valid = 1'b0;
    key_code  = 5'h00;
    rst       = 1'b0;
    @(posedge sw_clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    key_valid = 1'b0;
    key_code  = 5'h00;
    rst       = 1'b0;
    @(posedge sw_clk);
    #1;
    n_checks++; if (pb !== 16'hFFFF) $display("FAIL reset_pb got %h exp ffff", pb); else n_pass++;
    n_checks++; if (key_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", key_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (drop !== 1'b0) $display("FAIL reset_drop got %b exp 0", drop); else n_pass++;
    rst = 1'b1;
    model_clear();
    repeat (10) begin
      tick();
      n_checks++; if (pb !== 16'hFFFF || key_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL idle t=%0d got pb=%h rdy=%b busy=%b exp ffff/1/0", t, pb, key_ready, busy);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    int a;
    int first_low = -1;
    int nlow = 0;
    apply_reset();
    key_valid = 1'b1;
    key_code  = 5'h11;
    tick();
    a = t;
    key_valid = 1'b0;
    repeat (14) begin
      tick();
      n_checks++; if (pb !== exp_pb(t)) $display("FAIL single_pb t=%0d got %h exp %h", t, pb, exp_pb(t)); else n_pass++;
      n_checks++; if (busy !== exp_busy(t)) $display("FAIL single_busy t=%0d got %b exp %b", t, busy, exp_busy(t)); else n_pass++;
      if (pb == 16'hFFFE) begin
        nlow++;
        if (first_low < 0) first_low = t;
      end
    end
    n_checks++; if (nlow !== P) $display("FAIL single_press_len got %0d exp %0d", nlow, P); else n_pass++;
    n_checks++; if (first_low - a !== 1) $display("FAIL single_latency got %0d exp 1", first_low - a); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  seq[5]      = '{5'h11, 5'h12, 5'h13, 5'h1C, 5'h1F};
    int          exp_bits[5] = '{0, 1, 2, 11, 15};
    int          starts[$];
    int          bits[$];
    int          idx = 0;
    logic [15:0] prev = 16'hFFFF;
    apply_reset();
    key_valid = 1'b1;
    key_code  = seq[0];
    repeat (60) begin
      tick();
      if (last_acc) begin
        idx++;
        if (idx < 5) key_code = seq[idx];
        else key_valid = 1'b0;
      end
      n_checks++; if (pb !== exp_pb(t)) $display("FAIL b2b_pb t=%0d got %h exp %h", t, pb, exp_pb(t)); else n_pass++;
      n_checks++; if ($countones(~pb) > 1) $display("FAIL b2b_onehot t=%0d got %h exp at most one low", t, pb); else n_pass++;
      if (pb != 16'hFFFF && prev == 16'hFFFF) begin
        starts.push_back(t);
        bits.push_back(low_bit(pb));
      end
      prev = pb;
    end
    n_checks++; if (starts.size() !== 5) $display("FAIL b2b_count got %0d exp 5", starts.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (bits[i] !== exp_bits[i]) $display("FAIL b2b_bit%0d got %0d exp %0d", i, bits[i], exp_bits[i]); else n_pass++;
        if (i > 0) begin
          n_checks++; if (starts[i] - starts[i-1] !== P + R + 1)
            $display("FAIL b2b_period%0d got %0d exp %0d", i, starts[i] - starts[i-1], P + R + 1);
          else n_pass++;
        end
      end
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_flood();
    logic [4:0]  codes[10];
    int          obs[$];
    int          idx = 0;
    bit          saw_full = 1'b0;
    logic [15:0] prev = 16'hFFFF;
    apply_reset();
    for (int i = 0; i < 10; i++) codes[i] = 5'(5'h10 | 5'($urandom_range(0, 15)));
    key_valid = 1'b1;
    key_code  = codes[0];
    for (int c = 0; c < 140; c++) begin
      tick();
      if (last_acc) begin
        idx++;
        if (idx < 10) key_code = codes[idx];
        else key_valid = 1'b0;
      end
      n_checks++; if (key_ready !== exp_ready(t)) $display("FAIL flood_ready t=%0d got %b exp %b", t, key_ready, exp_ready(t)); else n_pass++;
      n_checks++; if (pb !== exp_pb(t)) $display("FAIL flood_pb t=%0d got %h exp %h", t, pb, exp_pb(t)); else n_pass++;
      if (!key_ready) saw_full = 1'b1;
      if (pb != 16'hFFFF && prev == 16'hFFFF) obs.push_back(low_bit(pb));
      prev = pb;
    end
    n_checks++; if (saw_full !== 1'b1) $display("FAIL flood_full got ready never low exp low once"); else n_pass++;
    n_checks++; if (obs.size() !== 10) $display("FAIL flood_played got %0d exp 10", obs.size());
    else begin
      n_pass++;
      for (int i = 0; i < 10; i++) begin
        n_checks++; if (obs[i] !== bit_of[codes[i][3:0]])
          $display("FAIL flood_order%0d got bit %0d exp bit %0d", i, obs[i], bit_of[codes[i][3:0]]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_drop();
    int ndrop = 0;
    apply_reset();
    key_valid = 1'b1;
    key_code  = 5'h05;
    tick();
    key_valid = 1'b0;
    n_checks++; if (drop !== 1'b1) $display("FAIL drop_pulse got %b exp 1", drop); else n_pass++;
    ndrop = 1;
    repeat (12) begin
      tick();
      if (drop) ndrop++;
      n_checks++; if (pb !== 16'hFFFF || busy !== 1'b0)
        $display("FAIL drop_quiet t=%0d got pb=%h busy=%b exp ffff/0", t, pb, busy);
      else n_pass++;
    end
    n_checks++; if (ndrop !== 1) $display("FAIL drop_once got %0d exp 1", ndrop); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 340; i++) begin
      if (i >= 300) begin
        key_valid = 1'b0;
      end else if (!(key_valid && !last_acc)) begin
        key_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 4) == 0) key_code = 5'($urandom_range(0, 15));
        else key_code = 5'(5'h10 | 5'($urandom_range(0, 15)));
      end
      tick();
      n_checks++; if (pb !== exp_pb(t)) $display("FAIL rnd_pb t=%0d got %h exp %h", t, pb, exp_pb(t)); else n_pass++;
      n_checks++; if (busy !== exp_busy(t)) $display("FAIL rnd_busy t=%0d got %b exp %b", t, busy, exp_busy(t)); else n_pass++;
      n_checks++; if (key_ready !== exp_ready(t)) $display("FAIL rnd_ready t=%0d got %b exp %b", t, key_ready, exp_ready(t)); else n_pass++;
      n_checks++; if (drop !== exp_drop) $display("FAIL rnd_drop t=%0d got %b exp %b", t, drop, exp_drop); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_press();
    int found = 0;
    apply_reset();
    key_valid = 1'b1;
    key_code  = 5'h1F;
    tick();
    key_code  = 5'h11;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (pb === 16'h7FFF) found = 1;
    end
    n_checks++; if (found !== 1) $display("FAIL midrst_press_seen got pb=%h exp 7fff within 10 cycles", pb); else n_pass++;
    tick();
    n_checks++; if (pb !== 16'h7FFF) $display("FAIL midrst_still_pressed got %h exp 7fff", pb); else n_pass++;
    #3;
    rst = 1'b0;
    #1;
    n_checks++; if (pb !== 16'hFFFF) $display("FAIL midrst_pb got %h exp ffff", pb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (key_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", key_ready); else n_pass++;
    @(posedge sw_clk);
    #1;
    rst = 1'b1;
    model_clear();
    repeat (12) begin
      tick();
      n_checks++; if (pb !== 16'hFFFF || busy !== 1'b0)
        $display("FAIL midrst_flushed t=%0d got pb=%h busy=%b exp ffff/0", t, pb, busy);
      else n_pass++;
    end
  endtask

`ifdef KEYPAD_PLAYER_CHECK_EN
  task automatic test_check();
    eBCD_in = 5'h00;
    apply_reset();
    key_valid = 1'b1;
    key_code  = 5'h13;
    tick();
    key_valid = 1'b0;
    repeat (12) begin
      tick();
      if (!pb[2]) eBCD_in = 5'h13;
    end
    n_checks++; if (mismatch !== 1'b0) $display("FAIL chk_good got %b exp 0", mismatch); else n_pass++;
    eBCD_in   = 5'h00;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (12) begin
      tick();
      if (!pb[2]) eBCD_in = 5'h12;
    end
    n_checks++; if (mismatch !== 1'b1) $display("FAIL chk_wrong got %b exp 1", mismatch); else n_pass++;
    eBCD_in = 5'h00;
    repeat (5) tick();
    n_checks++; if (mismatch !== 1'b1) $display("FAIL chk_sticky got %b exp 1", mismatch); else n_pass++;
    apply_reset();
    n_checks++; if (mismatch !== 1'b0) $display("FAIL chk_reset got %b exp 0", mismatch); else n_pass++;
    key_valid = 1'b1;
    key_code  = 5'h13;
    tick();
    key_valid = 1'b0;
    repeat (12) tick();
    n_checks++; if (mismatch !== 1'b1) $display("FAIL chk_missing got %b exp 1", mismatch); else n_pass++;
  endtask
`endif

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 5'h00;
`ifdef KEYPAD_PLAYER_CHECK_EN
    eBCD_in   = 5'h00;
`endif
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_flood();
    test_drop();
    test_random();
    test_reset_mid_press();
`ifdef KEYPAD_PLAYER_CHECK_EN
    test_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_keypad_player
`default_nettype wire
